// File: rtl/fmc_mailbox_if.sv
// FMC BRAM-port bus bundle: word address, access strobe, byte
// write enables, write data and 2-cycle-latency read data.
// Ports: master = host side, slave = mailbox side.
interface fmc_mailbox_if #(
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_DATA_WIDTH = 16
) ();
    logic [C_ADDR_WIDTH-1:0]   bram_addr;
    logic                      bram_en;
    logic [C_DATA_WIDTH/8-1:0] bram_we;
    logic [C_DATA_WIDTH-1:0]   bram_din;
    logic [C_DATA_WIDTH-1:0]   bram_dout;

    modport master (
        output bram_addr,
        output bram_en,
        output bram_we,
        output bram_din,
        input  bram_dout
    );

    modport slave (
        input  bram_addr,
        input  bram_en,
        input  bram_we,
        input  bram_din,
        output bram_dout
    );
endinterface

// File: rtl/fmc_mailbox.sv
// FMC mailbox: register file on the BRAM port with a TX FIFO to m_axis,
// an RX FIFO from s_axis, and a level irq for pending RX data.
// Ports: bram_clk, bram_rstn, bram (slave bus), m_axis_*, s_axis_*, irq.
module fmc_mailbox #(
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_DATA_WIDTH = 16,
    parameter int C_FIFO_DEPTH = 16
) (
    input  logic                    bram_clk,
    input  logic                    bram_rstn,
    fmc_mailbox_if.slave            bram,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic                    irq
);
    localparam int PW = $clog2(C_FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int WW = C_DATA_WIDTH / 8;
    localparam logic [LW-1:0] FULL = LW'(C_FIFO_DEPTH);
    localparam logic [C_ADDR_WIDTH-1:0] A_ID   = C_ADDR_WIDTH'(0);
    localparam logic [C_ADDR_WIDTH-1:0] A_CTRL = C_ADDR_WIDTH'(1);
    localparam logic [C_ADDR_WIDTH-1:0] A_STAT = C_ADDR_WIDTH'(2);
    localparam logic [C_ADDR_WIDTH-1:0] A_TX   = C_ADDR_WIDTH'(3);
    localparam logic [C_ADDR_WIDTH-1:0] A_RX   = C_ADDR_WIDTH'(4);
    localparam logic [C_ADDR_WIDTH-1:0] A_SCR  = C_ADDR_WIDTH'(5);

    logic [C_DATA_WIDTH-1:0] tx_mem [C_FIFO_DEPTH];
    logic [C_DATA_WIDTH-1:0] rx_mem [C_FIFO_DEPTH];
    logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [LW-1:0] tx_cnt, rx_cnt;

    logic irq_en, tx_ovf, rx_udf, wr_err, rdy_q;
    logic [C_DATA_WIDTH-1:0] scratch;
    logic s1_vld;
    logic [C_DATA_WIDTH-1:0] s1_dat, dout_q, rd_val;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic [8:0] lvl9;
    logic [7:0] rx_level;

    logic sel_id, sel_ctrl, sel_stat, sel_tx, sel_rx, sel_scr;
    logic is_wr, is_rd, we_all, w1c;
    logic tx_flush, rx_flush;
    logic tx_push_req, tx_push, tx_pop, tx_ovf_set, wr_err_set;
    logic rx_rd, rx_push, rx_pop, rx_udf_set;

    assign tx_full  = (tx_cnt == FULL);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL);
    assign rx_empty = (rx_cnt == '0);

    // Level field is 8 bits; a 256-deep FIFO would overflow it.
    assign lvl9     = 9'(rx_cnt);
    assign rx_level = (lvl9 > 9'd255) ? 8'hFF : lvl9[7:0];

    assign sel_id   = (bram.bram_addr == A_ID);
    assign sel_ctrl = (bram.bram_addr == A_CTRL);
    assign sel_stat = (bram.bram_addr == A_STAT);
    assign sel_tx   = (bram.bram_addr == A_TX);
    assign sel_rx   = (bram.bram_addr == A_RX);
    assign sel_scr  = (bram.bram_addr == A_SCR);

    assign is_wr  = bram.bram_en && (|bram.bram_we);
    assign is_rd  = bram.bram_en && !(|bram.bram_we);
    assign we_all = &bram.bram_we;
    assign w1c    = is_wr && sel_stat && bram.bram_we[0];

    assign tx_flush = is_wr && sel_ctrl && bram.bram_we[0] && bram.bram_din[0];
    assign rx_flush = is_wr && sel_ctrl && bram.bram_we[0] && bram.bram_din[1];

    assign tx_push_req = is_wr && sel_tx && we_all;
    assign wr_err_set  = is_wr && sel_tx && !we_all;
    assign tx_pop      = m_axis_tvalid && m_axis_tready && !tx_flush;
    // A full FIFO still accepts a push when it is popped in the same cycle.
    assign tx_push     = tx_push_req && !tx_flush && (!tx_full || tx_pop);
    assign tx_ovf_set  = tx_push_req && tx_full && !tx_pop;

    assign rx_rd      = is_rd && sel_rx;
    assign rx_pop     = rx_rd && !rx_empty && !rx_flush;
    assign rx_udf_set = rx_rd && rx_empty;
    assign rx_push    = s_axis_tvalid && rdy_q && !rx_flush
                        && (!rx_full || rx_pop);

    assign m_axis_tvalid  = !tx_empty;
    assign m_axis_tdata   = tx_mem[tx_rp];
    assign s_axis_tready  = rdy_q && !rx_full;
    assign bram.bram_dout = dout_q;

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            sel_id:   rd_val = 16'h4D42;
            sel_ctrl: rd_val = {13'b0, irq_en, 2'b0};
            sel_stat: rd_val = {rx_level, 1'b0, wr_err, rx_udf, tx_ovf,
                                rx_empty, rx_full, tx_empty, tx_full};
            sel_rx:   rd_val = rx_empty ? '0 : rx_mem[rx_rp];
            sel_scr:  rd_val = scratch;
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge bram_clk) begin
        if (tx_push) tx_mem[tx_wp] <= bram.bram_din;
        if (rx_push) rx_mem[rx_wp] <= s_axis_tdata;
    end

    always_ff @(posedge bram_clk or negedge bram_rstn) begin
        if (!bram_rstn) begin
            tx_wp   <= '0;
            tx_rp   <= '0;
            tx_cnt  <= '0;
            rx_wp   <= '0;
            rx_rp   <= '0;
            rx_cnt  <= '0;
            irq_en  <= 1'b0;
            tx_ovf  <= 1'b0;
            rx_udf  <= 1'b0;
            wr_err  <= 1'b0;
            rdy_q   <= 1'b0;
            scratch <= '0;
            s1_vld  <= 1'b0;
            s1_dat  <= '0;
            dout_q  <= '0;
            irq     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;

            if (tx_flush) begin
                tx_wp  <= '0;
                tx_rp  <= '0;
                tx_cnt <= '0;
            end else begin
                if (tx_push) tx_wp <= tx_wp + PW'(1);
                if (tx_pop)  tx_rp <= tx_rp + PW'(1);
                tx_cnt <= tx_cnt + LW'(tx_push) - LW'(tx_pop);
            end

            if (rx_flush) begin
                rx_wp  <= '0;
                rx_rp  <= '0;
                rx_cnt <= '0;
            end else begin
                if (rx_push) rx_wp <= rx_wp + PW'(1);
                if (rx_pop)  rx_rp <= rx_rp + PW'(1);
                rx_cnt <= rx_cnt + LW'(rx_push) - LW'(rx_pop);
            end

            if (is_wr && sel_ctrl && bram.bram_we[0])
                irq_en <= bram.bram_din[2];

            // A new event in the clearing cycle wins over the clear.
            tx_ovf <= (tx_ovf && !(w1c && bram.bram_din[4])) || tx_ovf_set;
            rx_udf <= (rx_udf && !(w1c && bram.bram_din[5])) || rx_udf_set;
            wr_err <= (wr_err && !(w1c && bram.bram_din[6])) || wr_err_set;

            for (int b = 0; b < WW; b++) begin
                if (is_wr && sel_scr && bram.bram_we[b])
                    scratch[8*b +: 8] <= bram.bram_din[8*b +: 8];
            end

            s1_vld <= is_rd;
            if (is_rd)  s1_dat <= rd_val;
            if (s1_vld) dout_q <= s1_dat;

            irq <= irq_en && !rx_empty;
        end
    end
endmodule
